// File: rtl/mvau_weight_sched_if.sv
// Weight-side bus of one MVAU PE scheduler.
//   wmem_addr / wmem_out : read port of the weight memory (one-cycle registered read)
//   w_valid / w_ready    : weight stream handshake toward the compute datapath
//   w_data               : weight word at the stream head
//   w_sf_last/w_nf_last  : fold-boundary tags of the head word
// master = scheduler, slave = memory + datapath.
interface mvau_weight_sched_if #(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int WMEM_ADDR_BW = 4
);
  logic [WMEM_ADDR_BW-1:0] wmem_addr;
  logic [SIMD*TW-1:0]      wmem_out;
  logic                    w_valid;
  logic                    w_ready;
  logic [SIMD*TW-1:0]      w_data;
  logic                    w_sf_last;
  logic                    w_nf_last;

  modport master (
    output wmem_addr, input wmem_out,
    output w_valid, input w_ready, output w_data, w_sf_last, w_nf_last
  );

  modport slave (
    input wmem_addr, output wmem_out,
    input w_valid, output w_ready, input w_data, w_sf_last, w_nf_last
  );
endinterface

// File: rtl/mvau_weight_sched.sv
// Weight sequencer / read controller for one MVAU PE.
// Walks the weight memory in synapse-fold / neuron-fold order NUM_VEC times per
// start, hides the one-cycle memory read latency behind a 2-entry FWFT FIFO and
// presents the words as a valid/ready stream tagged with fold boundaries.
// Ports:
//   aclk, aresetn : clock, async active-low reset
//   start         : run request, only honoured in IDLE
//   busy          : run in progress (RUN or DRAIN)
//   done          : one-cycle pulse once the last beat has been consumed
//   wif (master)  : memory read port + weight stream (see mvau_weight_sched_if)
module mvau_weight_sched #(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int SF           = 2,
  parameter int NF           = 2,
  parameter int NUM_VEC      = 4,
  parameter int WMEM_ADDR_BW = 4
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic start,
  output logic busy,
  output logic done,
  mvau_weight_sched_if.master wif
);

  localparam int W      = SIMD * TW;
  localparam int SF_BW  = (SF > 1)      ? $clog2(SF)      : 1;
  localparam int NF_BW  = (NF > 1)      ? $clog2(NF)      : 1;
  localparam int VEC_BW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;

  localparam logic [WMEM_ADDR_BW-1:0] ADDR_LAST = WMEM_ADDR_BW'(SF * NF - 1);
  localparam logic [SF_BW-1:0]        SF_LAST   = SF_BW'(SF - 1);
  localparam logic [NF_BW-1:0]        NF_LAST   = NF_BW'(NF - 1);
  localparam logic [VEC_BW-1:0]       VEC_LAST  = VEC_BW'(NUM_VEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [W-1:0] data;
    logic         sf_last;
    logic         nf_last;
  } beat_t;

  state_t state, state_nxt;

  logic [SF_BW-1:0]  sf_cnt;
  logic [NF_BW-1:0]  nf_cnt;
  logic [VEC_BW-1:0] vec_cnt;

  // One read outstanding at the memory; its fold tags travel alongside.
  logic inflight, infl_sf_last, infl_nf_last;

  beat_t [1:0] fifo;
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;

  logic pop, push, issue, sf_wrap, nf_wrap, last_issue;

  assign pop  = wif.w_valid & wif.w_ready;
  assign push = inflight;

  // Credit check: FIFO occupancy plus the read in flight, minus what leaves
  // this cycle, must leave room for the new word. count<=2 and inflight<=1,
  // and pop implies count>=1, so 2-bit arithmetic never wraps.
  assign issue = (state == RUN) &&
                 ((count + {1'b0, inflight} - {1'b0, pop}) < 2'd2);

  assign sf_wrap    = (sf_cnt == SF_LAST);
  assign nf_wrap    = (nf_cnt == NF_LAST);
  assign last_issue = issue & sf_wrap & nf_wrap & (vec_cnt == VEC_LAST);

  // ---------------- FSM ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    unique case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN:   if (last_issue) state_nxt = DRAIN;
      // Empty FIFO and nothing in flight means every beat has been popped,
      // so done can never coincide with w_valid.
      DRAIN: if (!inflight && (count == 2'd0)) begin
               done      = 1'b1;
               state_nxt = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // ---------------- address / fold counters ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wif.wmem_addr <= '0;
      sf_cnt        <= '0;
      nf_cnt        <= '0;
      vec_cnt       <= '0;
      inflight      <= 1'b0;
      infl_sf_last  <= 1'b0;
      infl_nf_last  <= 1'b0;
    end else begin
      inflight <= issue;
      if ((state == IDLE) && start) begin
        wif.wmem_addr <= '0;
        sf_cnt        <= '0;
        nf_cnt        <= '0;
        vec_cnt       <= '0;
      end else if (issue) begin
        infl_sf_last  <= sf_wrap;
        infl_nf_last  <= sf_wrap & nf_wrap;
        wif.wmem_addr <= (wif.wmem_addr == ADDR_LAST) ? '0 : wif.wmem_addr + 1'b1;
        sf_cnt        <= sf_wrap ? '0 : sf_cnt + 1'b1;
        if (sf_wrap) begin
          nf_cnt <= nf_wrap ? '0 : nf_cnt + 1'b1;
          if (nf_wrap) vec_cnt <= (vec_cnt == VEC_LAST) ? '0 : vec_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------- 2-entry FWFT FIFO ----------------
  // Reads of a held address are never pushed: only a tagged in-flight read
  // produces a push, so spurious memory output is ignored.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fifo   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= '{data: wif.wmem_out, sf_last: infl_sf_last, nf_last: infl_nf_last};
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign wif.w_valid   = (count != 2'd0);
  assign wif.w_data    = fifo[rd_ptr].data;
  // Tags are qualified so a stale entry never shows a boundary when idle.
  assign wif.w_sf_last = wif.w_valid & fifo[rd_ptr].sf_last;
  assign wif.w_nf_last = wif.w_valid & fifo[rd_ptr].nf_last;

endmodule

// File: tb/tb_mvau_weight_sched.sv
// Randomized self-checking bench for mvau_weight_sched.
// The expected beat stream is built from the fold-order rule
// (vector -> neuron fold -> synapse fold, address nf*SF+sf) and consumed by a
// scoreboard sampled on the falling clock edge.
module tb_mvau_weight_sched;
  localparam int SIMD = 4, TW = 2, SF = 2, NF = 2, NUM_VEC = 2, ABW = 4;
  localparam int W = SIMD * TW;
  localparam int DEPTH = SF * NF;
  localparam int BEATS = NUM_VEC * SF * NF;

  logic aclk, aresetn, start, busy, done;
  mvau_weight_sched_if #(.SIMD(SIMD), .TW(TW), .WMEM_ADDR_BW(ABW)) wif();

  mvau_weight_sched #(
    .SIMD(SIMD), .TW(TW), .SF(SF), .NF(NF), .NUM_VEC(NUM_VEC), .WMEM_ADDR_BW(ABW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .busy(busy), .done(done), .wif(wif)
  );

  logic [W-1:0] mem [0:DEPTH-1];
  always @(posedge aclk) wif.wmem_out <= mem[wif.wmem_addr];

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;

  // scoreboard state
  logic [W-1:0] exp_data [0:255];
  logic         exp_sfl  [0:255];
  logic         exp_nfl  [0:255];
  int exp_wr = 0, exp_rd = 0;
  int issued = 0, popped = 0, beats = 0, done_cnt = 0;
  int first_cyc, last_cyc, done_cyc, start_cyc = 0;
  bit first_seen, was_stall;
  logic [ABW-1:0] prev_addr = '0;
  int mode = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic monitor();
    if (!aresetn) begin
      issued = 0; popped = 0; prev_addr = '0; exp_rd = exp_wr; was_stall = 0;
      return;
    end
    if (wif.wmem_addr != prev_addr) begin
      issued++;
      prev_addr = wif.wmem_addr;
      chk("issue_addr", 32'(wif.wmem_addr), 32'(issued % DEPTH));
    end
    chk("credit_le2", 32'((issued - popped) <= 2), 1);
    if (was_stall) chk("stall_hold_valid", 32'(wif.w_valid), 1);
    if (wif.w_valid) begin
      if (exp_rd < exp_wr) begin
        chk("head_data", 32'(wif.w_data), 32'(exp_data[exp_rd]));
        chk("head_sf_last", 32'(wif.w_sf_last), 32'(exp_sfl[exp_rd]));
        chk("head_nf_last", 32'(wif.w_nf_last), 32'(exp_nfl[exp_rd]));
        if (wif.w_ready) begin
          exp_rd++; popped++; beats++; last_cyc = cyc;
          if (!first_seen) begin first_seen = 1; first_cyc = cyc; end
        end
      end else begin
        chk("valid_without_beat", 32'(wif.w_valid), 0);
      end
    end
    if (done) begin
      done_cnt++; done_cyc = cyc;
      chk("done_wo_valid", 32'(wif.w_valid), 0);
      chk("done_all_popped", 32'(exp_wr - exp_rd), 0);
    end
    was_stall = wif.w_valid & ~wif.w_ready;
  endtask

  // Drive inputs just after the rising edge, then check at the falling edge.
  task automatic tick(input bit st);
    int rel;
    @(posedge aclk); #1;
    start = st;
    rel = cyc - start_cyc;
    case (mode)
      0: wif.w_ready = 1'b1;
      1: wif.w_ready = (rel % 3 == 0);
      2: wif.w_ready = 1'($urandom_range(0, 1));
      default: wif.w_ready = (rel > 20);
    endcase
    @(negedge aclk);
    monitor();
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_busy"},    32'(busy), 0);
    chk({p, "_done"},    32'(done), 0);
    chk({p, "_addr"},    32'(wif.wmem_addr), 0);
    chk({p, "_valid"},   32'(wif.w_valid), 0);
    chk({p, "_sf_last"}, 32'(wif.w_sf_last), 0);
    chk({p, "_nf_last"}, 32'(wif.w_nf_last), 0);
    chk({p, "_data"},    32'(wif.w_data), 0);
  endtask

  task automatic do_run(input int m, input int restart_at, input int rst_at);
    int b0, d0, iss0;
    bit rs, fin;
    for (int a = 0; a < DEPTH; a++) mem[a] = {2'(a), 6'($urandom)};
    for (int v = 0; v < NUM_VEC; v++)
      for (int n = 0; n < NF; n++)
        for (int s = 0; s < SF; s++) begin
          exp_data[exp_wr] = mem[n * SF + s];
          exp_sfl[exp_wr]  = (s == SF - 1);
          exp_nfl[exp_wr]  = (s == SF - 1) && (n == NF - 1);
          exp_wr++;
        end
    mode = m; b0 = beats; d0 = done_cnt; iss0 = issued;
    first_seen = 0; rs = 0; fin = 0;
    start_cyc = cyc + 1;
    tick(1'b1);
    for (int i = 0; i < 400 && !fin; i++) begin
      tick(rs == 0 && restart_at > 0 && (beats - b0) >= restart_at);
      if (start) rs = 1;
      if (m == 3 && (cyc - start_cyc) == 20) begin
        chk("hold_addr", 32'(wif.wmem_addr), 2);
        chk("hold_issues", 32'(issued - iss0), 2);
        chk("hold_no_beats", 32'(beats - b0), 0);
        chk("hold_valid", 32'(wif.w_valid), 1);
      end
      if (rst_at > 0 && (beats - b0) >= rst_at) begin
        aresetn = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tick(1'b0);
        aresetn = 1'b1;
        repeat (4) tick(1'b0);
        chk("midrst_no_done", 32'(done_cnt - d0), 0);
        chk("midrst_idle", 32'(busy), 0);
        return;
      end
      if (done_cnt != d0) fin = 1;
    end
    chk("run_done", 32'(done_cnt - d0), 1);
    chk("beat_count", 32'(beats - b0), BEATS);
    if (m == 0) begin
      chk("lat_first_beat", 32'(first_cyc - start_cyc), 3);
      chk("lat_last_beat", 32'(last_cyc - start_cyc), 2 + BEATS);
      chk("lat_done", 32'(done_cyc - start_cyc), 3 + BEATS);
    end
    tick(1'b0);
    chk("busy_after_done", 32'(busy), 0);
    repeat (5) tick(1'b0);
    chk("single_done", 32'(done_cnt - d0), 1);
    chk("still_idle", 32'(busy), 0);
  endtask

  initial begin
    aresetn = 1'b0; start = 1'b0; wif.w_ready = 1'b0;
    for (int a = 0; a < DEPTH; a++) mem[a] = '0;
    repeat (2) @(negedge aclk);
    chk_reset_vals("rst");
    aresetn = 1'b1;
    repeat (2) tick(1'b0);

    do_run(0, 0, 0);   // basic run + latency/throughput
    do_run(1, 0, 0);   // 1,0,0 backpressure
    repeat (3) do_run(2, 0, 0);  // random backpressure
    do_run(3, 0, 0);   // long hold-off then release
    do_run(0, 3, 0);   // start while busy is ignored
    do_run(0, 0, 5);   // reset mid-run
    do_run(0, 0, 0);   // restart from addr 0 after reset

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
